// File: rtl/decode_ctrl.sv
// decode_ctrl: decode-stage controller between fetch and execute.
// Two-entry skid buffer (head + skid) with valid/ready on both sides.
// Each entry carries pc, raw instruction, captured immediate and an
// illegal-encoding flag. Also provides branch-redirect flush and
// back-pressure / dispatch counters.
module decode_ctrl #(
    parameter int DWIDTH   = 32,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    // fetch side
    input  logic                f_valid_i,
    input  logic [DWIDTH-1:0]   f_insn_i,
    input  logic [DWIDTH-1:0]   f_pc_i,
    output logic                f_ready_o,
    input  logic                flush_i,
    // immediate generator
    output logic [6:0]          igen_opcode_o,
    output logic [DWIDTH-1:0]   igen_insn_o,
    input  logic [DWIDTH-1:0]   igen_imm_i,
    // execute side
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [DWIDTH-1:0]   d_pc_o,
    output logic [DWIDTH-1:0]   d_insn_o,
    output logic [6:0]          d_opcode_o,
    output logic [4:0]          d_rd_o,
    output logic [4:0]          d_rs1_o,
    output logic [4:0]          d_rs2_o,
    output logic [2:0]          d_funct3_o,
    output logic [6:0]          d_funct7_o,
    output logic [DWIDTH-1:0]   d_imm_o,
    output logic                d_illegal_o,
    // counters
    output logic [STALL_CW-1:0] stall_cnt_o,
    output logic [31:0]         dec_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // RV32 base opcodes accepted as legal
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Illegal when not a 32-bit encoding or the major opcode is unknown.
    function automatic logic is_illegal(input logic [6:0] opc);
        logic known;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
                known = 1'b1;
            default:
                known = 1'b0;
        endcase
        return (opc[1:0] != 2'b11) || !known;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_f_ready;

    logic [DWIDTH-1:0]     r_hd_pc;
    logic [DWIDTH-1:0]     r_hd_insn;
    logic [DWIDTH-1:0]     r_hd_imm;
    logic                  r_hd_ill;

    logic [DWIDTH-1:0]     r_sk_pc;
    logic [DWIDTH-1:0]     r_sk_insn;
    logic [DWIDTH-1:0]     r_sk_imm;
    logic                  r_sk_ill;

    logic [STALL_CW-1:0]   r_stall_cnt;
    logic [31:0]           r_dec_cnt;

    logic                  w_valid;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_in_ill;
    logic                  w_ld_head_in;
    logic                  w_ld_head_sk;
    logic                  w_ld_skid;

    assign w_valid  = (r_state != ST_EMPTY);
    assign w_enq    = f_valid_i & r_f_ready & ~flush_i;
    assign w_deq    = w_valid & d_ready_i;
    assign w_in_ill = is_illegal(f_insn_i[6:0]);

    // Next-state and entry-load decisions; flush overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_ld_head_in = 1'b0;
        w_ld_head_sk = 1'b0;
        w_ld_skid    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_enq) begin
                    w_state_nxt  = ST_ONE;
                    w_ld_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_enq && w_deq) begin
                    w_state_nxt  = ST_ONE;
                    w_ld_head_in = 1'b1;
                end else if (w_enq) begin
                    w_state_nxt  = ST_FULL;
                    w_ld_skid    = 1'b1;
                end else if (w_deq) begin
                    w_state_nxt  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // ready is low here, so no enqueue is possible
                if (w_deq) begin
                    w_state_nxt  = ST_ONE;
                    w_ld_head_sk = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush_i) begin
            w_state_nxt  = ST_EMPTY;
            w_ld_head_in = 1'b0;
            w_ld_head_sk = 1'b0;
            w_ld_skid    = 1'b0;
        end
    end

    // State register; ready is registered from the next state so it has
    // no combinational dependence on d_ready_i or f_valid_i.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_EMPTY;
            r_f_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_f_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Head entry: loaded from fetch (with same-cycle immediate) or from skid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hd_pc   <= '0;
            r_hd_insn <= '0;
            r_hd_imm  <= '0;
            r_hd_ill  <= 1'b0;
        end else if (w_ld_head_in) begin
            r_hd_pc   <= f_pc_i;
            r_hd_insn <= f_insn_i;
            r_hd_imm  <= igen_imm_i;
            r_hd_ill  <= w_in_ill;
        end else if (w_ld_head_sk) begin
            r_hd_pc   <= r_sk_pc;
            r_hd_insn <= r_sk_insn;
            r_hd_imm  <= r_sk_imm;
            r_hd_ill  <= r_sk_ill;
        end
    end

    // Skid entry: catches the instruction that arrives while head is stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sk_pc   <= '0;
            r_sk_insn <= '0;
            r_sk_imm  <= '0;
            r_sk_ill  <= 1'b0;
        end else if (w_ld_skid) begin
            r_sk_pc   <= f_pc_i;
            r_sk_insn <= f_insn_i;
            r_sk_imm  <= igen_imm_i;
            r_sk_ill  <= w_in_ill;
        end
    end

    // Back-pressure counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !d_ready_i && (r_stall_cnt != {STALL_CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CW'(1);
        end
    end

    // Dispatch counter; a dispatch in a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dec_cnt <= '0;
        end else if (w_deq) begin
            r_dec_cnt <= r_dec_cnt + 32'd1;
        end
    end

    assign f_ready_o     = r_f_ready;
    assign igen_opcode_o = f_insn_i[6:0];
    assign igen_insn_o   = f_insn_i;

    assign d_valid_o     = w_valid;
    assign d_pc_o        = r_hd_pc;
    assign d_insn_o      = r_hd_insn;
    assign d_opcode_o    = r_hd_insn[6:0];
    assign d_rd_o        = r_hd_insn[11:7];
    assign d_rs1_o       = r_hd_insn[19:15];
    assign d_rs2_o       = r_hd_insn[24:20];
    assign d_funct3_o    = r_hd_insn[14:12];
    assign d_funct7_o    = r_hd_insn[31:25];
    assign d_imm_o       = r_hd_imm;
    assign d_illegal_o   = r_hd_ill;
    assign stall_cnt_o   = r_stall_cnt;
    assign dec_cnt_o     = r_dec_cnt;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed bench for decode_ctrl with a reference
// immediate generator on the igen_* interface.
module tb_decode_ctrl;

    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk;
    logic          reset_n;
    logic          f_valid_i;
    logic [DW-1:0] f_insn_i;
    logic [DW-1:0] f_pc_i;
    logic          f_ready_o;
    logic          flush_i;
    logic [6:0]    igen_opcode_o;
    logic [DW-1:0] igen_insn_o;
    logic [DW-1:0] igen_imm_i;
    logic          d_valid_o;
    logic          d_ready_i;
    logic [DW-1:0] d_pc_o;
    logic [DW-1:0] d_insn_o;
    logic [6:0]    d_opcode_o;
    logic [4:0]    d_rd_o;
    logic [4:0]    d_rs1_o;
    logic [4:0]    d_rs2_o;
    logic [2:0]    d_funct3_o;
    logic [6:0]    d_funct7_o;
    logic [DW-1:0] d_imm_o;
    logic          d_illegal_o;
    logic [SW-1:0] stall_cnt_o;
    logic [31:0]   dec_cnt_o;

    int n_chk;
    int n_err;

    decode_ctrl #(.DWIDTH(DW), .STALL_CW(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_valid_i(f_valid_i), .f_insn_i(f_insn_i), .f_pc_i(f_pc_i),
        .f_ready_o(f_ready_o), .flush_i(flush_i),
        .igen_opcode_o(igen_opcode_o), .igen_insn_o(igen_insn_o),
        .igen_imm_i(igen_imm_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .d_pc_o(d_pc_o), .d_insn_o(d_insn_o), .d_opcode_o(d_opcode_o),
        .d_rd_o(d_rd_o), .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o),
        .d_funct3_o(d_funct3_o), .d_funct7_o(d_funct7_o),
        .d_imm_o(d_imm_o), .d_illegal_o(d_illegal_o),
        .stall_cnt_o(stall_cnt_o), .dec_cnt_o(dec_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RV32 immediate generator; unknown opcodes return 0.
    always_comb begin
        logic [31:0] i;
        i = igen_insn_o;
        case (igen_opcode_o)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111:
                igen_imm_i = {{20{i[31]}}, i[31:20]};
            7'b0100011:
                igen_imm_i = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011:
                igen_imm_i = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                igen_imm_i = {i[31:12], 12'b0};
            7'b1101111:
                igen_imm_i = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                igen_imm_i = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
        f_valid_i = v;
        f_insn_i  = insn;
        f_pc_i    = pc;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset_n   = 1'b0;
        flush_i   = 1'b0;
        d_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // reset state
        tick();
        tick();
        chk("rst_valid", {31'b0, d_valid_o}, 32'd0);
        chk("rst_ready", {31'b0, f_ready_o}, 32'd0);
        chk("rst_dec", dec_cnt_o, 32'd0);
        chk("rst_stall", {16'b0, stall_cnt_o}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, f_ready_o}, 32'd1);

        // single addi x1,x0,5
        drive(1'b1, 32'h00500093, 32'h100);
        d_ready_i = 1'b1;
        tick();
        chk("addi_valid", {31'b0, d_valid_o}, 32'd1);
        chk("addi_pc", d_pc_o, 32'h100);
        chk("addi_rd", {27'b0, d_rd_o}, 32'd1);
        chk("addi_rs1", {27'b0, d_rs1_o}, 32'd0);
        chk("addi_imm", d_imm_o, 32'h5);
        chk("addi_ill", {31'b0, d_illegal_o}, 32'd0);
        chk("addi_dec0", dec_cnt_o, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("addi_dec1", dec_cnt_o, 32'd1);
        chk("addi_empty", {31'b0, d_valid_o}, 32'd0);

        // fill to FULL with beq then lui under back-pressure
        d_ready_i = 1'b0;
        drive(1'b1, 32'hFE000EE3, 32'h200);
        tick();
        chk("beq_ready", {31'b0, f_ready_o}, 32'd1);
        drive(1'b1, 32'h123452B7, 32'h204);
        tick();
        chk("full_ready", {31'b0, f_ready_o}, 32'd0);
        chk("beq_imm", d_imm_o, 32'hFFFFFFFC);
        chk("beq_insn", d_insn_o, 32'hFE000EE3);
        chk("stall_1", {16'b0, stall_cnt_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("stall_2", {16'b0, stall_cnt_o}, 32'd2);
        chk("beq_hold", d_pc_o, 32'h200);
        d_ready_i = 1'b1;
        tick();
        chk("lui_pc", d_pc_o, 32'h204);
        chk("lui_imm", d_imm_o, 32'h12345000);
        chk("lui_rd", {27'b0, d_rd_o}, 32'd5);
        chk("lui_dec", dec_cnt_o, 32'd2);
        chk("lui_stall", {16'b0, stall_cnt_o}, 32'd2);
        chk("lui_ready", {31'b0, f_ready_o}, 32'd1);
        tick();
        chk("lui_dec3", dec_cnt_o, 32'd3);

        // steady stream of 8 after a fresh reset
        do_reset();
        d_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13, 32'h1000 + 32'(4 * k));
            tick();
            chk("strm_pc", d_pc_o, 32'h1000 + 32'(4 * k));
            chk("strm_imm", d_imm_o, 32'(k));
            chk("strm_ready", {31'b0, f_ready_o}, 32'd1);
            chk("strm_dec", dec_cnt_o, 32'(k));
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("strm_dec8", dec_cnt_o, 32'd8);
        chk("strm_stall0", {16'b0, stall_cnt_o}, 32'd0);

        // flush while FULL with an incoming instruction
        d_ready_i = 1'b0;
        drive(1'b1, 32'h00100113, 32'h300);
        tick();
        drive(1'b1, 32'h00200193, 32'h304);
        tick();
        chk("fl_full", {31'b0, f_ready_o}, 32'd0);
        flush_i = 1'b1;
        drive(1'b1, 32'h00300213, 32'h308);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_valid", {31'b0, d_valid_o}, 32'd0);
        chk("fl_ready", {31'b0, f_ready_o}, 32'd1);
        chk("fl_stall", {16'b0, stall_cnt_o}, 32'd2);
        d_ready_i = 1'b1;
        tick();
        tick();
        chk("fl_gone", {31'b0, d_valid_o}, 32'd0);
        chk("fl_dec", dec_cnt_o, 32'd8);

        // dispatch in the flush cycle still counts
        d_ready_i = 1'b0;
        drive(1'b1, 32'h00400293, 32'h30C);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        flush_i   = 1'b1;
        d_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_deq_dec", dec_cnt_o, 32'd9);
        chk("fl_deq_valid", {31'b0, d_valid_o}, 32'd0);

        // illegal encodings flow in order with zero immediate
        d_ready_i = 1'b0;
        drive(1'b1, 32'h00000000, 32'h400);
        tick();
        chk("ill0_flag", {31'b0, d_illegal_o}, 32'd1);
        chk("ill0_imm", d_imm_o, 32'd0);
        drive(1'b1, 32'h0000007F, 32'h404);
        tick();
        chk("ill0_hold", d_pc_o, 32'h400);
        drive(1'b0, 32'h0, 32'h0);
        d_ready_i = 1'b1;
        tick();
        chk("ill7f_pc", d_pc_o, 32'h404);
        chk("ill7f_flag", {31'b0, d_illegal_o}, 32'd1);
        chk("ill7f_imm", d_imm_o, 32'd0);
        chk("ill_dec", dec_cnt_o, 32'd10);
        tick();
        chk("ill_dec2", dec_cnt_o, 32'd11);

        // reset while FULL with stall count 5
        do_reset();
        d_ready_i = 1'b0;
        drive(1'b1, 32'h00500093, 32'h500);
        tick();
        drive(1'b1, 32'h00600113, 32'h504);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_stall", {16'b0, stall_cnt_o}, 32'd5);
        reset_n = 1'b0;
        tick();
        chk("mrst_valid", {31'b0, d_valid_o}, 32'd0);
        chk("mrst_ready", {31'b0, f_ready_o}, 32'd0);
        chk("mrst_stall", {16'b0, stall_cnt_o}, 32'd0);
        chk("mrst_pc", d_pc_o, 32'd0);
        chk("mrst_insn", d_insn_o, 32'd0);
        chk("mrst_imm", d_imm_o, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("mrst_gone", {31'b0, d_valid_o}, 32'd0);

        // stall counter saturation
        drive(1'b1, 32'h00700393, 32'h600);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        force dut.r_stall_cnt = 16'hFFFD;
        #1;
        release dut.r_stall_cnt;
        tick();
        chk("sat_fffe", {16'b0, stall_cnt_o}, 32'h0000FFFE);
        tick();
        chk("sat_ffff", {16'b0, stall_cnt_o}, 32'h0000FFFF);
        tick();
        chk("sat_hold", {16'b0, stall_cnt_o}, 32'h0000FFFF);

        // dispatch counter wrap
        force dut.r_dec_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_dec_cnt;
        d_ready_i = 1'b1;
        tick();
        chk("dec_wrap", dec_cnt_o, 32'd0);
        chk("wrap_empty", {31'b0, d_valid_o}, 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $finish;
    end

endmodule
